// File: rtl/mips16_mc_ctrl_if.sv
// Control handshake bundle between the MIPS16 multicycle controller and its datapath.
// The controller is the slave: it samples start/opcode/zero/mem_ready and drives the rest.
interface mips16_mc_ctrl_if;
  logic       start;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       ir_write;
  logic       pc_write;
  logic       branch_sig;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       mem_req;
  logic       mem_we;
  logic       alusrc;
  logic [2:0] aluop;
  logic       busy;
  logic       halted;
  logic       err;

  modport master (
    output start, opcode, zero, mem_ready,
    input  ir_write, pc_write, branch_sig, reg_write, reg_dst, mem_to_reg,
           mem_req, mem_we, alusrc, aluop, busy, halted, err
  );

  modport slave (
    input  start, opcode, zero, mem_ready,
    output ir_write, pc_write, branch_sig, reg_write, reg_dst, mem_to_reg,
           mem_req, mem_we, alusrc, aluop, busy, halted, err
  );
endinterface

// File: rtl/mips16_mc_ctrl.sv
// MIPS16 multicycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT), Moore outputs.
// Define MIPS16_CTRL_PERF_CNT_EN to add saturating cycle_count/instr_count outputs.
module mips16_mc_ctrl (
  input  logic            clock,
  input  logic            reset,
  mips16_mc_ctrl_if.slave bus
`ifdef MIPS16_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_count,
  output logic [15:0]     instr_count
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       err_q, err_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_HALT: state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          default:       state_d = S_FETCH;  // only BEQ can reach EXEC otherwise
        endcase
      end
      S_MEM:    if (bus.mem_ready) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  logic is_r, is_lw, is_sw, is_beq;
  assign is_r   = (op_q == OP_R);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);

  // Outputs decode only state_q and the latched opcode; zero feeds branch_sig alone.
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch_sig = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alusrc     = 1'b0;
    bus.aluop      = ALU_RTYPE;
    bus.busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    bus.halted     = (state_q == S_HALT);
    bus.err        = (state_q == S_HALT) && err_q;
    case (state_q)
      S_FETCH: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_EXEC: begin
        if (is_beq) begin
          bus.aluop      = ALU_SUB;
          bus.branch_sig = bus.zero;
        end else if (!is_r) begin
          bus.aluop  = ALU_ADD;
          bus.alusrc = 1'b1;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = is_sw;
        bus.aluop   = ALU_ADD;
        bus.alusrc  = 1'b1;
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = is_r;
        bus.mem_to_reg = is_lw;
        bus.aluop      = is_r ? ALU_RTYPE : ALU_ADD;
        bus.alusrc     = !is_r;
      end
      default: ;
    endcase
  end

`ifdef MIPS16_CTRL_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d, ins_q, ins_d;
  logic        busy_now, instr_done;

  always_comb begin
    busy_now   = (state_q != S_IDLE) && (state_q != S_HALT);
    // An instruction retires when control returns to FETCH or halts cleanly.
    instr_done = ((state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) ||
                 ((state_d == S_HALT) && (state_q != S_HALT) && !err_d);
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (busy_now && (cyc_q != 16'hFFFF))   cyc_d = cyc_q + 16'd1;
    if (instr_done && (ins_q != 16'hFFFF)) ins_d = ins_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`endif

endmodule

// File: tb/tb_mips16_mc_ctrl.sv
// Self-checking bench for mips16_mc_ctrl: fixed vector table, random instruction stream
// expanded from per-instruction cycle scripts, and hand sequences for reset/halt corners.
module tb_mips16_mc_ctrl;

  logic clock;
  logic reset;
  mips16_mc_ctrl_if bus_if ();

`ifdef MIPS16_CTRL_PERF_CNT_EN
  logic [15:0] cycle_count, instr_count;
  mips16_mc_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );
`else
  mips16_mc_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector: {0, ir, pc, br, rw, rd, m2r, mreq, mwe, asrc, aluop[2:0], busy, halted, err}
  localparam logic [15:0] B_IR   = 16'h4000;
  localparam logic [15:0] B_PC   = 16'h2000;
  localparam logic [15:0] B_BR   = 16'h1000;
  localparam logic [15:0] B_RW   = 16'h0800;
  localparam logic [15:0] B_RD   = 16'h0400;
  localparam logic [15:0] B_M2R  = 16'h0200;
  localparam logic [15:0] B_MREQ = 16'h0100;
  localparam logic [15:0] B_MWE  = 16'h0080;
  localparam logic [15:0] B_ASRC = 16'h0040;
  localparam logic [15:0] A_ADD  = 16'h0008;
  localparam logic [15:0] A_SUB  = 16'h0010;
  localparam logic [15:0] B_BUSY = 16'h0004;
  localparam logic [15:0] B_HLT  = 16'h0002;
  localparam logic [15:0] B_ERR  = 16'h0001;

  localparam logic [15:0] V_IDLE     = 16'h0000;
  localparam logic [15:0] V_FETCH    = B_IR | B_PC | B_BUSY;
  localparam logic [15:0] V_DEC      = B_BUSY;
  localparam logic [15:0] V_EX_R     = B_BUSY;
  localparam logic [15:0] V_EX_I     = B_BUSY | B_ASRC | A_ADD;
  localparam logic [15:0] V_EX_BEQ   = B_BUSY | A_SUB;
  localparam logic [15:0] V_MEM_LW   = B_BUSY | B_MREQ | B_ASRC | A_ADD;
  localparam logic [15:0] V_MEM_SW   = V_MEM_LW | B_MWE;
  localparam logic [15:0] V_WB_R     = B_BUSY | B_RW | B_RD;
  localparam logic [15:0] V_WB_ADDI  = B_BUSY | B_RW | B_ASRC | A_ADD;
  localparam logic [15:0] V_WB_LW    = V_WB_ADDI | B_M2R;
  localparam logic [15:0] V_HALT_OK  = B_HLT;
  localparam logic [15:0] V_HALT_ERR = B_HLT | B_ERR;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ILL  = 6'b110000;

  typedef struct {
    logic        start;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [15:0] exp;
  } vec_t;

  logic [15:0] act_o;
  assign act_o = {1'b0, bus_if.ir_write, bus_if.pc_write, bus_if.branch_sig, bus_if.reg_write,
                  bus_if.reg_dst, bus_if.mem_to_reg, bus_if.mem_req, bus_if.mem_we,
                  bus_if.alusrc, bus_if.aluop, bus_if.busy, bus_if.halted, bus_if.err};

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t q[$];
  vec_t tbl[19];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs, check outputs of the current state, advance one clock.
  task automatic apply(input vec_t v, input string tag, input int idx);
    bus_if.start     = v.start;
    bus_if.opcode    = v.opcode;
    bus_if.zero      = v.zero;
    bus_if.mem_ready = v.mem_ready;
    #1;
    check($sformatf("%s[%0d]", tag, idx), act_o, v.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic run_queue(input string tag);
    foreach (q[i]) apply(q[i], tag, i);
    q.delete();
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  // Junk on start/opcode/zero/mem_ready wherever the controller must ignore them.
  task automatic push(input logic s, input logic [5:0] o, input logic z, input logic m,
                      input logic [15:0] e);
    vec_t v;
    v.start = s; v.opcode = o; v.zero = z; v.mem_ready = m; v.exp = e;
    q.push_back(v);
  endtask

  // Reference: one instruction as its cycle-by-cycle script from FETCH entry.
  task automatic push_instr(input logic [5:0] op, input logic z, input int w);
    push(rb(), ro(), rb(), rb(), V_FETCH);
    push(rb(), op,   rb(), rb(), V_DEC);
    case (op)
      OP_R:    begin push(rb(), ro(), rb(), rb(), V_EX_R); push(rb(), ro(), rb(), rb(), V_WB_R); end
      OP_ADDI: begin push(rb(), ro(), rb(), rb(), V_EX_I); push(rb(), ro(), rb(), rb(), V_WB_ADDI); end
      OP_BEQ:  push(rb(), ro(), z, rb(), V_EX_BEQ | (z ? B_BR : 16'h0000));
      default: begin
        push(rb(), ro(), rb(), rb(), V_EX_I);
        for (int k = 0; k < w; k++)
          push(rb(), ro(), rb(), 1'b0, (op == OP_SW) ? V_MEM_SW : V_MEM_LW);
        push(rb(), ro(), rb(), 1'b1, (op == OP_SW) ? V_MEM_SW : V_MEM_LW);
        if (op == OP_LW) push(rb(), ro(), rb(), rb(), V_WB_LW);
      end
    endcase
  endtask

  task automatic push_halt(input logic [5:0] op, input int n, input logic e);
    push(rb(), ro(), rb(), rb(), V_FETCH);
    push(rb(), op,   rb(), rb(), V_DEC);
    for (int k = 0; k < n; k++) push(k[0], ro(), rb(), rb(), e ? V_HALT_ERR : V_HALT_OK);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus_if.start = 1'b1;
    bus_if.mem_ready = 1'b1;
    bus_if.zero = 1'b1;
    #1;
    check({tag, "_during_reset"}, act_o, V_IDLE);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    bus_if.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[5];
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};

    tbl = '{
      '{1'b1, 6'h00, 1'b0, 1'b0, V_IDLE},
      '{1'b1, 6'h2B, 1'b1, 1'b1, V_FETCH},
      '{1'b0, OP_R,  1'b0, 1'b0, V_DEC},
      '{1'b1, 6'h3F, 1'b1, 1'b1, V_EX_R},
      '{1'b0, 6'h23, 1'b0, 1'b1, V_WB_R},
      '{1'b0, 6'h00, 1'b0, 1'b0, V_FETCH},
      '{1'b0, OP_BEQ, 1'b0, 1'b0, V_DEC},
      '{1'b0, 6'h00, 1'b1, 1'b1, V_EX_BEQ | B_BR},
      '{1'b0, 6'h00, 1'b1, 1'b0, V_FETCH},
      '{1'b0, OP_BEQ, 1'b1, 1'b0, V_DEC},
      '{1'b0, 6'h00, 1'b0, 1'b1, V_EX_BEQ},
      '{1'b0, 6'h00, 1'b0, 1'b1, V_FETCH},
      '{1'b0, OP_LW, 1'b0, 1'b1, V_DEC},
      '{1'b1, 6'h2B, 1'b0, 1'b1, V_EX_I},
      '{1'b1, 6'h2B, 1'b0, 1'b0, V_MEM_LW},
      '{1'b0, 6'h00, 1'b1, 1'b0, V_MEM_LW},
      '{1'b1, 6'h3F, 1'b0, 1'b0, V_MEM_LW},
      '{1'b0, 6'h00, 1'b0, 1'b1, V_MEM_LW},
      '{1'b0, 6'h00, 1'b0, 1'b0, V_WB_LW}
    };

    reset = 1'b1;
    bus_if.start = 1'b0; bus_if.opcode = '0; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b0;
    do_reset("init");
`ifdef MIPS16_CTRL_PERF_CNT_EN
    check("cnt_reset_cycle", cycle_count, 16'h0000);
    check("cnt_reset_instr", instr_count, 16'h0000);
`endif

    // Stay in IDLE until start is sampled.
    for (int i = 0; i < 3; i++) push(1'b0, ro(), rb(), rb(), V_IDLE);
    run_queue("idle_hold");

    foreach (tbl[i]) apply(tbl[i], "tbl", i);

    // Random instruction stream, continuing from the FETCH the table left behind.
    repeat (40) push_instr(ops[$urandom_range(0, 4)], rb(), int'($urandom_range(0, 3)));
    run_queue("rand");

    // Reset in the middle of an SW memory wait.
    do_reset("pre_mem");
    push(1'b1, ro(), rb(), rb(), V_IDLE);
    push(rb(), ro(), rb(), rb(), V_FETCH);
    push(rb(), OP_SW, rb(), rb(), V_DEC);
    push(rb(), ro(), rb(), rb(), V_EX_I);
    push(rb(), ro(), rb(), 1'b0, V_MEM_SW);
    run_queue("sw_wait");
    bus_if.mem_ready = 1'b0;
    #1 check("mid_mem_before_reset", act_o, V_MEM_SW);
    reset = 1'b1;
    #1 check("mid_mem_reset_same_cycle", act_o, V_IDLE);
    bus_if.mem_ready = 1'b1;
    @(posedge clock); #1;
    check("mid_mem_reset_held", act_o, V_IDLE);
    reset = 1'b0;
    bus_if.start = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, ro(), rb(), 1'b1, V_IDLE);
    run_queue("post_mem_reset");

    // Reset during WB of an R-type.
    push(1'b1, ro(), rb(), rb(), V_IDLE);
    push(rb(), ro(), rb(), rb(), V_FETCH);
    push(rb(), OP_R, rb(), rb(), V_DEC);
    push(rb(), ro(), rb(), rb(), V_EX_R);
    run_queue("r_pre_wb");
    #1 check("mid_wb_before_reset", act_o, V_WB_R);
    reset = 1'b1;
    #1 check("mid_wb_reset_same_cycle", act_o, V_IDLE);
    @(posedge clock); #1;
    reset = 1'b0;
    bus_if.start = 1'b0;

`ifdef MIPS16_CTRL_PERF_CNT_EN
    do_reset("perf");
    push(1'b1, ro(), rb(), rb(), V_IDLE);
    push_instr(OP_ADDI, 1'b0, 0);
    push_instr(OP_SW, 1'b0, 0);
    push_halt(OP_HALT, 3, 1'b0);
    run_queue("perf");
    check("perf_instr_count", instr_count, 16'd3);
    check("perf_cycle_count", cycle_count, 16'd10);
`endif

    // Illegal opcode: HALT with err, start pulses ignored for 10 cycles.
    do_reset("ill");
    push(1'b1, ro(), rb(), rb(), V_IDLE);
    push_halt(OP_ILL, 10, 1'b1);
    run_queue("illegal_halt");

    // HALT opcode: clean halt.
    do_reset("halt");
    push(1'b1, ro(), rb(), rb(), V_IDLE);
    push_halt(OP_HALT, 10, 1'b0);
    run_queue("halt_op");

    do_reset("final");
    #1 check("final_idle", act_o, V_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
